// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   md_op_e             : decoded MDOp codes driven by the decoder
//   *_CYCLES_DEFAULT    : default busy durations for multiply and divide
//   md_is_start_op()    : true for the ops that launch a timed computation
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    function automatic logic md_is_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// The 64-bit result is computed behaviourally at the accept edge and parked
// in hi_tmp/lo_tmp; it is committed to HI/LO only when the busy countdown
// expires, so software sees a fixed multi-cycle latency.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   MDOp   : decoded MD operation of the E-stage instruction
//   Start  : one-cycle pulse for mult/multu/div/divu
//   A, B   : forwarded rs / rt operands
//   Busy   : computation in flight (registered)
//   HI, LO : architectural HI/LO registers
//   MDOut  : mfhi -> HI, mflo -> LO, otherwise 0 (combinational)
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi_reg, lo_reg;
    logic [31:0]      hi_tmp_reg, lo_tmp_reg;
    logic             commit_en_reg;
    logic [CNT_W-1:0] count_reg;
    logic             busy_reg;

    // Arithmetic results for the op currently presented on MDOp/A/B.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        [31:0] res_hi, res_lo;
    logic               res_commit;
    logic [CNT_W-1:0]   res_cycles;
    logic               start_accept;

    always_comb begin
        prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u     = {32'd0, A} * {32'd0, B};
        quot_s     = '0;
        rem_s      = '0;
        quot_u     = '0;
        rem_u      = '0;
        res_hi     = '0;
        res_lo     = '0;
        res_commit = 1'b0;
        res_cycles = '0;

        // Division is only evaluated for a non-zero divisor; a zero divisor
        // still runs the full busy period but suppresses the commit.
        if (B != 32'd0) begin
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                // The only signed quotient that does not fit in 32 bits.
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
            quot_u = A / B;
            rem_u  = A % B;
        end

        case (MDOp)
            MD_MULT: begin
                res_hi     = prod_s[63:32];
                res_lo     = prod_s[31:0];
                res_commit = 1'b1;
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
                res_hi     = prod_u[63:32];
                res_lo     = prod_u[31:0];
                res_commit = 1'b1;
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
                res_hi     = rem_s;
                res_lo     = quot_s;
                res_commit = (B != 32'd0);
                res_cycles = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
                res_hi     = rem_u;
                res_lo     = quot_u;
                res_commit = (B != 32'd0);
                res_cycles = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    assign start_accept = Start && !busy_reg && md_is_start_op(MDOp);

    // busy_reg mirrors (count_reg != 0) but is kept as its own flop so Busy
    // leaves the unit straight from a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_reg        <= '0;
            lo_reg        <= '0;
            hi_tmp_reg    <= '0;
            lo_tmp_reg    <= '0;
            commit_en_reg <= 1'b0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
        end else if (busy_reg) begin
            // Anything presented while busy is ignored; only the countdown runs.
            count_reg <= count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
                if (commit_en_reg) begin
                    hi_reg <= hi_tmp_reg;
                    lo_reg <= lo_tmp_reg;
                end
            end
        end else if (start_accept) begin
            hi_tmp_reg    <= res_hi;
            lo_tmp_reg    <= res_lo;
            commit_en_reg <= res_commit;
            count_reg     <= res_cycles;
            busy_reg      <= 1'b1;
        end else if (MDOp == MD_MTHI) begin
            hi_reg <= A;
        end else if (MDOp == MD_MTLO) begin
            lo_reg <= A;
        end
    end

    always_comb begin
        MDOut = '0;
        case (MDOp)
            MD_MFHI: MDOut = hi_reg;
            MD_MFLO: MDOut = lo_reg;
            default: ;
        endcase
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios followed by
// randomized operations, checked against a 64-bit integer reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  MDOp  = 4'd0;
    logic        Start = 1'b0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO, MDOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .MDOp  (MDOp),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain 64-bit integer arithmetic on the operands.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p, q, r;
        longint unsigned pu;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            MD_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                ref_hi = pu[63:32];
                ref_lo = pu[31:0];
            end
            MD_DIV: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                ref_lo = q[31:0];
                ref_hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            MD_MTHI: ref_hi = a;
            MD_MTLO: ref_lo = a;
            default: ;
        endcase
    endfunction

    task automatic read_back(input string tag);
        MDOp = MD_MFHI; #1;
        check({tag, " mfhi"}, MDOut, ref_hi);
        MDOp = MD_MFLO; #1;
        check({tag, " mflo"}, MDOut, ref_lo);
        MDOp = MD_NONE; #1;
        check({tag, " mdout idle"}, MDOut, 32'd0);
    endtask

    // Launch a timed op; optionally inject a Start and an mthi while busy.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input bit intrude);
        int          n;
        logic [31:0] old_hi, old_lo;
        n = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
        MDOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MD_NONE;
        old_hi = ref_hi;
        old_lo = ref_lo;
        model(op, a, b);
        for (int i = 1; i <= n; i++) begin
            check({tag, " busy"}, {31'd0, Busy}, 32'd1);
            if (i == n) begin
                check({tag, " hi held"}, HI, old_hi);
                check({tag, " lo held"}, LO, old_lo);
            end
            if (intrude && i == 3) begin
                MDOp = MD_MULT; A = 32'd4; B = 32'd4; Start = 1'b1;
            end else if (intrude && i == 4) begin
                Start = 1'b0; MDOp = MD_MTHI; A = 32'h0BAD_0BAD;
            end else begin
                Start = 1'b0; MDOp = MD_NONE;
            end
            tick();
        end
        MDOp = MD_NONE; Start = 1'b0;
        check({tag, " busy end"}, {31'd0, Busy}, 32'd0);
        check({tag, " hi"}, HI, ref_hi);
        check({tag, " lo"}, LO, ref_lo);
        read_back(tag);
        $display("op %0d a=%h b=%h -> hi=%h lo=%h", op, a, b, HI, LO);
    endtask

    task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
        MDOp = op; A = a;
        tick();
        MDOp = MD_NONE;
        model(op, a, 32'd0);
        check({tag, " busy"}, {31'd0, Busy}, 32'd0);
        check({tag, " hi"}, HI, ref_hi);
        check({tag, " lo"}, LO, ref_lo);
        $display("mt op %0d a=%h -> hi=%h lo=%h", op, a, HI, LO);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          sel;

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        check("reset mdout", MDOut, 32'd0);

        // mult -3*5.
        do_op("mult neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check("mult neg hi const", HI, 32'hFFFF_FFFF);
        check("mult neg lo const", LO, 32'hFFFF_FFF1);

        // multu and mult of the same operands.
        do_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu hi const", HI, 32'h0000_0001);
        check("multu lo const", LO, 32'hFFFF_FFFE);
        do_op("mult same", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult same hi const", HI, 32'hFFFF_FFFF);
        check("mult same lo const", LO, 32'hFFFF_FFFE);

        // Signed divide -7/2.
        do_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div lo const", LO, 32'hFFFF_FFFD);
        check("div hi const", HI, 32'hFFFF_FFFF);

        // Divide by zero leaves HI/LO alone.
        do_mt("mthi 11", MD_MTHI, 32'h11);
        do_mt("mtlo 22", MD_MTLO, 32'h22);
        do_op("divu by0", MD_DIVU, 32'd7, 32'd0, 1'b0);
        check("divu by0 hi const", HI, 32'h11);
        check("divu by0 lo const", LO, 32'h22);

        // Signed divide overflow.
        do_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div ovf lo const", LO, 32'h8000_0000);
        check("div ovf hi const", HI, 32'h0);

        // Reset in the middle of a mult aborts it.
        MDOp = MD_MULT; A = 32'd2; B = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MD_NONE;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        check("abort busy", {31'd0, Busy}, 32'd0);
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("abort no commit hi", HI, 32'd0);
        check("abort no commit lo", LO, 32'd0);
        check("abort idle", {31'd0, Busy}, 32'd0);

        // mthi then mflo/mfhi.
        do_mt("mtlo seed", MD_MTLO, 32'h1234_5678);
        do_mt("mthi dead", MD_MTHI, 32'hDEAD_BEEF);
        MDOp = MD_MFLO; #1;
        check("mflo after mthi", MDOut, 32'h1234_5678);
        tick();
        MDOp = MD_MFHI; #1;
        check("mfhi after mthi", MDOut, 32'hDEAD_BEEF);
        MDOp = MD_NONE;

        // Start with a non-computing op is ignored.
        MDOp = MD_MFHI; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MD_NONE;
        check("bad start busy", {31'd0, Busy}, 32'd0);
        check("bad start hi", HI, ref_hi);

        // Start and mthi during a div are ignored.
        do_op("div intruded", MD_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
        check("div intruded lo const", LO, 32'hFFFF_FFF2);
        check("div intruded hi const", HI, 32'd2);

        // Randomized operations.
        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            case (sel)
                0: op = MD_MULT;
                1: op = MD_MULTU;
                2: op = MD_DIV;
                3: op = MD_DIVU;
                4: op = MD_MTHI;
                default: op = MD_MTLO;
            endcase
            if (sel >= 4) do_mt("rand mt", op, ra);
            else          do_op("rand op", op, ra, rb, k[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit for the pipelined MIPS core; executes mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Computes over a fixed multi-cycle latency and holds HI/LO state.
- Drives Busy directly upstream into the hazard/stall unit.
- The stall unit stalls any MD-class instruction in D while E_Start|E_Busy is high, so the D instruction stays in D and does not advance.

Parameters:
MULT_CYCLES, 5, Busy duration in cycles for mult/multu (>=1)
DIV_CYCLES, 10, Busy duration in cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
MDOp  input  4  decoded operation of the E-stage instruction (codes in def.v)
Start  input  1  one-cycle pulse: E instruction is mult/multu/div/divu
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
Busy  output  1  computation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDOut  output  32  mfhi -> HI, mflo -> LO, otherwise 0; combinational

Behaviour:
- Reset (reset==0 at edge):
  - HI=0, LO=0, counter=0, Busy=0; pending result discarded.
  - Reset mid-operation aborts the operation; no HI/LO commit follows.
- Start accept (edge where Start==1, Busy==0, reset==1, MDOp in {MULT,MULTU,DIV,DIVU}):
  - Latch the 64-bit result into internal hi_tmp/lo_tmp.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Busy = (counter != 0), registered.
  - Start at edge k: Busy is high in cycles k+1..k+N and low at k+N+1.
- Commit: at the edge where counter goes 1->0, HI<=hi_tmp and LO<=lo_tmp. New values are visible from cycle k+N+1, the same cycle Busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper word, LO = lower word.
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - div overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0, div or divu): Busy still runs for DIV_CYCLES; HI/LO are left unchanged at commit.
- mthi/mtlo (MDOp match, Busy==0): HI<=A or LO<=A at the edge. They are not gated by Start and have no busy period.
- Start or mthi/mtlo while Busy==1: ignored. This is a protocol violation the stall unit prevents; the unit must not corrupt the in-flight operation.
- Start with a non-mult/div MDOp: ignored.
- mthi/mtlo and Start in the same cycle cannot occur (single MDOp).
- MDOut is purely combinational from the current HI/LO and MDOp. mfhi in the cycle after an mthi edge returns the new value.
- A back-to-back Start is accepted at cycle k+N+1 at the earliest (Busy==0).

Decomposition:
- def.v gains the MDOp codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
- def.v also gains the MULT_CYCLES/DIV_CYCLES defaults.
- No sub-module is required. The arithmetic is behavioural (* / % with $signed) inside a single always block; the counter/commit logic sits in the same module.

Test Plan:
1. mult, A=0xFFFFFFFD (-3), B=5, Start at cycle 0:
   - Busy=1 in cycles 1-5, 0 in cycle 6.
   - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfhi MDOut=0xFFFFFFFF.
2. multu, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. The same operands with mult -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
3. div, A=-7, B=2:
   - Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu with A=7, B=0 after mthi/mtlo of 0x11/0x22: Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
4. mult 2*3 started, reset=0 asserted at cycle 3:
   - Cycle 4: Busy=0, HI=LO=0.
   - No commit at cycle 6.
5. mthi A=0xDEADBEEF, then mflo/mfhi next cycles -> MDOut=LO old / 0xDEADBEEF. A Start (mult 4*4) pulsed during Busy of a prior div is ignored: the div result commits and Busy lasts exactly 10 cycles.
